pixel_seq_ctrl: RTL and testbench



---
 rtl/pixel_seq_pkg.sv | 74 +++++++
 rtl/pixel_seq_ctrl_timer.sv | 43 ++++
 rtl/pixel_seq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pixel_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_seq_pkg.sv
// Shared definitions for the pixel-kernel sequencer: state encoding,
// default sizing constants and the state-to-switch-control decode.
// Optional feature macro: PXL_DUAL_SAMPLE_EN (adds the SAML state).
package pixel_seq_pkg;

    localparam int DEF_NUM_PIXELS = 9;
    localparam int DEF_TIMER_W    = 10;
    localparam int DEF_SAM_CYC    = 2;

    localparam logic [2:0] ENC_WAIT = 3'd0;
    localparam logic [2:0] ENC_LOC  = 3'd1;
    localparam logic [2:0] ENC_GAP  = 3'd2;
    localparam logic [2:0] ENC_ADJ  = 3'd3;
    localparam logic [2:0] ENC_SAM  = 3'd4;
    localparam logic [2:0] ENC_DONE = 3'd5;
`ifdef PXL_DUAL_SAMPLE_EN
    localparam logic [2:0] ENC_SAML = 3'd6;
`endif

    typedef enum logic [2:0] {
        ST_WAIT = ENC_WAIT,
        ST_LOC  = ENC_LOC,
        ST_GAP  = ENC_GAP,
        ST_ADJ  = ENC_ADJ,
        ST_SAM  = ENC_SAM,
`ifdef PXL_DUAL_SAMPLE_EN
        ST_SAML = ENC_SAML,
`endif
        ST_DONE = ENC_DONE
    } state_e;

    // Switch controls driven toward the pixel array, plus the done pulse.
    typedef struct packed {
        logic s_p1;
        logic s_p2;
        logic s1;
        logic s2;
        logic v_b1;
        logic sh;
        logic pxl_done;
    } ctrl_t;

    // Moore decode: every control depends on the registered state only.
    function automatic ctrl_t state_ctrl(input state_e st);
        ctrl_t c;
        c = '0;
        case (st)
            ST_LOC: begin
                c.s_p1 = 1'b1;
                c.s1   = 1'b1;
                c.v_b1 = 1'b1;
            end
            ST_ADJ: begin
                c.s_p2 = 1'b1;
                c.s2   = 1'b1;
                c.v_b1 = 1'b1;
            end
            ST_SAM: begin
                c.v_b1 = 1'b1;
                c.sh   = 1'b1;
            end
`ifdef PXL_DUAL_SAMPLE_EN
            ST_SAML: begin
                c.v_b1 = 1'b1;
                c.sh   = 1'b1;
            end
`endif
            ST_DONE: c.pxl_done = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pixel_seq_ctrl_timer.sv
// Phase timer shared by all sequencer states: clears on state entry,
// counts while enabled and flags when the count equals the terminal value.
// Optional feature macro PXL_DUAL_SAMPLE_EN does not affect this block.
module pxl_phase_timer
    import pixel_seq_pkg::*;
#(
    parameter int W = DEF_TIMER_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] max_i,
    output logic         at_max_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so all registers update from pre-edge values.
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == max_i);

endmodule

// File: rtl/pixel_seq_ctrl.sv
// Pixel-kernel sequencer: runs NUM_PIXELS pixels per start through
// LOC, GAP, ADJ, SAM and DONE, with continuous mode, abort and latched
// integration lengths. Optional feature macro: PXL_DUAL_SAMPLE_EN inserts
// a SAML sample/hold phase between LOC and GAP.
module pixel_seq_ctrl
    import pixel_seq_pkg::*;
#(
    parameter int NUM_PIXELS = DEF_NUM_PIXELS,
    parameter int TIMER_W    = DEF_TIMER_W,
    parameter int SAM_CYC    = DEF_SAM_CYC,
    parameter int IDX_W      = $clog2(NUM_PIXELS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               cont_mode_i,
    input  logic [TIMER_W-1:0] loc_max_clk_i,
    input  logic [TIMER_W-1:0] adj_max_clk_i,
    output logic               busy_o,
    output logic               s_p1,
    output logic               s_p2,
    output logic               s1,
    output logic               s2,
    output logic               v_b1,
    output logic               sh,
    output logic               s1_inv,
    output logic               s2_inv,
    output logic               v_b0,
    output logic               pxl_done_o,
    output logic               kernel_done_o,
    output logic [IDX_W-1:0]   pxl_idx_o,
    output logic               loc_timer_max_o,
    output logic               adj_timer_max_o
);

    localparam logic [TIMER_W-1:0] SAM_LAST = TIMER_W'(SAM_CYC - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_PIXELS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TIMER_W-1:0] loc_q, loc_d;
    logic [TIMER_W-1:0] adj_q, adj_d;
    logic [TIMER_W-1:0] tmr_max;
    logic               tmr_clr;
    logic               at_max;
    logic               last_pix;
    ctrl_t              ctrl;

    assign last_pix = (idx_q == IDX_LAST);

    // Terminal count for the phase timer in the current state.
    always_comb begin
        tmr_max = '0;
        case (state_q)
            ST_LOC:  tmr_max = loc_q;
            ST_ADJ:  tmr_max = adj_q;
            ST_SAM:  tmr_max = SAM_LAST;
`ifdef PXL_DUAL_SAMPLE_EN
            ST_SAML: tmr_max = SAM_LAST;
`endif
            default: tmr_max = '0;
        endcase
    end

    // The timer restarts on every state change and idles at zero in WAIT.
    assign tmr_clr = (state_d != state_q) || (state_q == ST_WAIT);

    pxl_phase_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (tmr_clr),
        .en_i     (busy_o),
        .max_i    (tmr_max),
        .at_max_o (at_max)
    );

    // Next state, pixel index and configuration latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        loc_d   = loc_q;
        adj_d   = adj_q;
        if (abort_i && (state_q != ST_WAIT)) begin
            state_d = ST_WAIT;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (start_i && !abort_i) begin
                        state_d = ST_LOC;
                        loc_d   = loc_max_clk_i;
                        adj_d   = adj_max_clk_i;
                    end
                end
                ST_LOC: begin
                    if (at_max) begin
`ifdef PXL_DUAL_SAMPLE_EN
                        state_d = ST_SAML;
`else
                        state_d = ST_GAP;
`endif
                    end
                end
`ifdef PXL_DUAL_SAMPLE_EN
                ST_SAML: begin
                    if (at_max) state_d = ST_GAP;
                end
`endif
                ST_GAP: state_d = ST_ADJ;
                ST_ADJ: begin
                    if (at_max) state_d = ST_SAM;
                end
                ST_SAM: begin
                    if (at_max) state_d = ST_DONE;
                end
                ST_DONE: begin
                    if (last_pix) begin
                        idx_d = '0;
                        if (cont_mode_i) begin
                            state_d = ST_LOC;
                            loc_d   = loc_max_clk_i;
                            adj_d   = adj_max_clk_i;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_LOC;
                    end
                end
                default: begin
                    state_d = ST_WAIT;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // State, index and latched configuration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_WAIT;
            idx_q   <= '0;
            loc_q   <= '0;
            adj_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            loc_q   <= loc_d;
            adj_q   <= adj_d;
        end
    end

    assign ctrl            = state_ctrl(state_q);
    assign s_p1            = ctrl.s_p1;
    assign s_p2            = ctrl.s_p2;
    assign s1              = ctrl.s1;
    assign s2              = ctrl.s2;
    assign v_b1            = ctrl.v_b1;
    assign sh              = ctrl.sh;
    assign s1_inv          = ~ctrl.s1;
    assign s2_inv          = ~ctrl.s2;
    assign v_b0            = ~ctrl.v_b1;
    assign pxl_done_o      = ctrl.pxl_done;
    assign kernel_done_o   = ctrl.pxl_done && last_pix;
    assign busy_o          = (state_q != ST_WAIT);
    assign pxl_idx_o       = idx_q;
    assign loc_timer_max_o = (state_q == ST_LOC) && at_max;
    assign adj_timer_max_o = (state_q == ST_ADJ) && at_max;

endmodule

// File: tb/tb_pixel_seq_ctrl.sv
// Scoreboard bench for pixel_seq_ctrl: stimulus pushes the expected done
// pulses (cycle, index, kernel flag, phase lengths); a monitor pops and
// compares on every pxl_done_o. Honours PXL_DUAL_SAMPLE_EN when defined.
module tb_pixel_seq_ctrl;

    localparam int NP  = 9;
    localparam int TW  = 10;
    localparam int SAM = 2;
`ifdef PXL_DUAL_SAMPLE_EN
    localparam int E = SAM;
`else
    localparam int E = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start_i, abort_i, cont_mode_i;
    logic [TW-1:0] loc_max_clk_i, adj_max_clk_i;
    logic          busy_o, s_p1, s_p2, s1, s2, v_b1, sh, s1_inv, s2_inv, v_b0;
    logic          pxl_done_o, kernel_done_o, loc_timer_max_o, adj_timer_max_o;
    logic [3:0]    pxl_idx_o;

    pixel_seq_ctrl #(
        .NUM_PIXELS (NP),
        .TIMER_W    (TW),
        .SAM_CYC    (SAM)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .cont_mode_i     (cont_mode_i),
        .loc_max_clk_i   (loc_max_clk_i),
        .adj_max_clk_i   (adj_max_clk_i),
        .busy_o          (busy_o),
        .s_p1            (s_p1),
        .s_p2            (s_p2),
        .s1              (s1),
        .s2              (s2),
        .v_b1            (v_b1),
        .sh              (sh),
        .s1_inv          (s1_inv),
        .s2_inv          (s2_inv),
        .v_b0            (v_b0),
        .pxl_done_o      (pxl_done_o),
        .kernel_done_o   (kernel_done_o),
        .pxl_idx_o       (pxl_idx_o),
        .loc_timer_max_o (loc_timer_max_o),
        .adj_timer_max_o (adj_timer_max_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int idx;
        int kd;
        int loc_len;
        int adj_len;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Expected done pulses for 'count' pixels starting at cycle s.
    task automatic push_pixels(input int s, input int loc, input int adj, input int count);
        int p;
        exp_t e;
        p = loc + adj + SAM + 4 + E;
        for (int n = 0; n < count; n++) begin
            e.cyc     = s + n * p + p - 1;
            e.idx     = n % NP;
            e.kd      = ((n % NP) == NP - 1) ? 1 : 0;
            e.loc_len = loc + 1;
            e.adj_len = adj + 1;
            sb.push_back(e);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Pulse start at a negedge; returns the cycle in which LOC is entered.
    task automatic do_start(output int s);
        start_i = 1'b1;
        @(negedge clk);
        s = cyc;
        start_i = 1'b0;
    endtask

    // Monitor: per-pixel phase statistics, compared at each done pulse.
    int c_loc, c_adj, c_sh, c_gap, c_lt, c_at, c_bad;
    always @(negedge clk) begin
        if (reset || !busy_o) begin
            c_loc = 0; c_adj = 0; c_sh = 0; c_gap = 0; c_lt = 0; c_at = 0; c_bad = 0;
        end else begin
            c_loc += int'(s_p1);
            c_adj += int'(s_p2);
            c_sh  += int'(sh);
            c_gap += int'(!s_p1 && !s_p2 && !sh && !v_b1 && !pxl_done_o);
            c_lt  += int'(loc_timer_max_o && s_p1);
            c_at  += int'(adj_timer_max_o && s_p2);
            c_bad += int'((s1_inv != ~s1) || (s2_inv != ~s2) || (v_b0 != ~v_b1) ||
                          (s1 != s_p1) || (s2 != s_p2) || (v_b1 != (s_p1 | s_p2 | sh)) ||
                          (loc_timer_max_o && !s_p1) || (adj_timer_max_o && !s_p2));
            if (kernel_done_o && !pxl_done_o) check("kd_without_done", 1, 0);
            if (pxl_done_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("done_idx", int'(pxl_idx_o), e.idx);
                    check("kernel_done", int'(kernel_done_o), e.kd);
                    check("loc_len", c_loc, e.loc_len);
                    check("adj_len", c_adj, e.adj_len);
                    check("sh_len", c_sh, SAM + E);
                    check("gap_len", c_gap, 1);
                    check("loc_tmax_hits", c_lt, 1);
                    check("adj_tmax_hits", c_at, 1);
                    check("ctrl_consistency", c_bad, 0);
                end
                c_loc = 0; c_adj = 0; c_sh = 0; c_gap = 0; c_lt = 0; c_at = 0; c_bad = 0;
            end
        end
    end

    task automatic check_wait_outputs(input string tag);
        check({tag, "_busy"}, int'(busy_o), 0);
        check({tag, "_idx"}, int'(pxl_idx_o), 0);
        check({tag, "_v_b0"}, int'(v_b0), 1);
        check({tag, "_s1_inv"}, int'(s1_inv), 1);
        check({tag, "_s2_inv"}, int'(s2_inv), 1);
        check({tag, "_pxl_done"}, int'(pxl_done_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, p, t;
        reset = 1'b1; start_i = 1'b0; abort_i = 1'b0; cont_mode_i = 1'b0;
        loc_max_clk_i = 10'd3; adj_max_clk_i = 10'd5;
        repeat (3) @(negedge clk);
        check_wait_outputs("reset");
        check("reset_kernel_done", int'(kernel_done_o), 0);
        reset = 1'b0;
        @(negedge clk);

        // Basic kernel loc=3 adj=5; a mid-kernel config change and start pulse are ignored.
        do_start(s);
        p = 3 + 5 + SAM + 4 + E;
        push_pixels(s, 3, 5, NP);
        check("k1_loc_entry", int'(s_p1), 1);
        wait_cyc(s + 30);
        loc_max_clk_i = 10'd7;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_cyc(s + NP * p - 1);
        check("k1_last_kd", int'(kernel_done_o), 1);
        @(negedge clk);
        check("k1_busy_fall", int'(busy_o), 0);
        check("k1_idx_wrap", int'(pxl_idx_o), 0);
        repeat (2) @(negedge clk);

        // Next kernel uses loc=7; abort in the 3rd ADJ cycle of pixel 4.
        do_start(s);
        p = 7 + 5 + SAM + 4 + E;
        push_pixels(s, 7, 5, 4);
        t = s + 4 * p + 7 + 4 + E;
        wait_cyc(t);
        check("abort_in_adj", int'(s_p2), 1);
        check("abort_idx4", int'(pxl_idx_o), 4);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check_wait_outputs("abort");
        repeat (2) @(negedge clk);

        // Start and abort together in WAIT: abort wins.
        start_i = 1'b1; abort_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; abort_i = 1'b0;
        check("start_abort_wait", int'(busy_o), 0);

        // Minimum lengths loc=0 adj=0, restart from index 0 after abort.
        loc_max_clk_i = 10'd0; adj_max_clk_i = 10'd0;
        do_start(s);
        p = 0 + 0 + SAM + 4 + E;
        push_pixels(s, 0, 0, NP);
        check("min_loc_tmax", int'(loc_timer_max_o), 1);
        wait_cyc(s + NP * p);
        check("min_busy_fall", int'(busy_o), 0);
        repeat (2) @(negedge clk);

        // Continuous mode: two back-to-back kernels.
        loc_max_clk_i = 10'd3; adj_max_clk_i = 10'd5;
        cont_mode_i = 1'b1;
        do_start(s);
        p = 3 + 5 + SAM + 4 + E;
        push_pixels(s, 3, 5, 2 * NP);
        wait_cyc(s + NP * p);
        check("cont_relaunch_loc", int'(s_p1), 1);
        check("cont_idx_wrap", int'(pxl_idx_o), 0);
        check("cont_busy", int'(busy_o), 1);
        cont_mode_i = 1'b0;
        wait_cyc(s + 2 * NP * p);
        check("cont_busy_fall", int'(busy_o), 0);
        repeat (2) @(negedge clk);

        // Reset during SAM of pixel 1 with start held high.
        start_i = 1'b1;
        @(negedge clk);
        s = cyc;
        push_pixels(s, 3, 5, 1);
        wait_cyc(s + p + 11 + E);
        check("rst_in_sam", int'(sh), 1);
        reset = 1'b1;
        @(negedge clk);
        check_wait_outputs("rst_mid");
        repeat (2) @(negedge clk);
        check("rst_hold_busy", int'(busy_o), 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_release_loc", int'(s_p1), 1);
        check("rst_release_idx", int'(pxl_idx_o), 0);
        start_i = 1'b0;
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("final_abort_busy", int'(busy_o), 0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
